// File: rtl/mnist_frame_pingpong_pkg.sv
// Shared types and constants for the ping-pong 28x28 frame buffer.
// Write FSM states, frame counter width and the image-size helper.
package mnist_frame_pkg;

  localparam int FRAME_ID_W = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_WAIT = 2'd2
  } wr_state_e;

  function automatic int img_size(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/mnist_frame_pingpong_frame_bank_ram.sv
// One image bank: simple dual-port RAM, one write port and one registered read port.
module frame_bank_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Pixel storage, intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register; holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mnist_frame_pingpong.sv
// Double-buffered image store: a streaming writer fills one bank while the
// reader randomly accesses the last published frame in the other bank.
module mnist_frame_pingpong
  import mnist_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_ROWS   = 28,
  parameter int IMG_COLS   = 28,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  sync_err,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  frame_avail,
  input  logic                  frame_release,
  output logic [FRAME_ID_W-1:0] frame_id
);

  localparam int IMG_SIZE = img_size(IMG_ROWS, IMG_COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_SIZE - 1);

  if (2 ** ADDR_WIDTH < IMG_SIZE) begin : g_addr_width_check
    $error("ADDR_WIDTH cannot address IMG_ROWS*IMG_COLS pixels");
  end

  wr_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic                  r_wbank;
  logic                  r_rbank;
  logic                  r_frame_avail;
  logic [FRAME_ID_W-1:0] r_frame_id;
  logic                  r_sync_err;
  logic                  r_rd_valid;
  logic                  r_rd_sel;
  logic                  r_rd_oob;

  logic                  w_accept;
  logic                  w_wen;
  logic                  w_last;
  logic                  w_publish;
  logic                  w_rd_in_range;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_rdata0;
  logic [DATA_WIDTH-1:0] w_rdata1;

  assign wr_ready      = (r_state != W_WAIT);
  assign w_accept      = wr_valid & wr_ready;
  assign w_wen         = w_accept & (wr_sof | (r_state == W_FILL));
  assign w_waddr       = wr_sof ? {ADDR_WIDTH{1'b0}} : r_wptr;
  assign w_last        = (r_state == W_FILL) & w_accept & ~wr_sof & (r_wptr == LAST_ADDR);
  // A finished frame may replace the published one only once the reader lets go.
  assign w_publish     = (w_last & (~r_frame_avail | frame_release))
                       | ((r_state == W_WAIT) & frame_release);
  assign w_rd_in_range = (32'(rd_addr) < IMG_SIZE);

  frame_bank_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_wen & ~r_wbank),
    .i_waddr(w_waddr),
    .i_wdata(wr_data),
    .i_re   (rd_en & w_rd_in_range),
    .i_raddr(rd_addr),
    .o_rdata(w_rdata0)
  );

  frame_bank_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_wen & r_wbank),
    .i_waddr(w_waddr),
    .i_wdata(wr_data),
    .i_re   (rd_en & w_rd_in_range),
    .i_raddr(rd_addr),
    .o_rdata(w_rdata1)
  );

  // Write FSM, bank ownership and frame publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= W_IDLE;
      r_wptr        <= {ADDR_WIDTH{1'b0}};
      r_wbank       <= 1'b0;
      r_rbank       <= 1'b1;
      r_frame_avail <= 1'b0;
      r_frame_id    <= {FRAME_ID_W{1'b0}};
      r_sync_err    <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      if (w_publish) begin
        r_rbank       <= r_wbank;
        r_wbank       <= ~r_wbank;
        r_frame_avail <= 1'b1;
        r_frame_id    <= r_frame_id + FRAME_ID_W'(1);
        r_wptr        <= {ADDR_WIDTH{1'b0}};
        r_state       <= W_IDLE;
      end else begin
        if (frame_release & r_frame_avail) begin
          r_frame_avail <= 1'b0;
        end
        case (r_state)
          W_IDLE: begin
            if (w_accept) begin
              if (wr_sof) begin
                r_wptr  <= ADDR_WIDTH'(1);
                r_state <= W_FILL;
              end else begin
                r_sync_err <= 1'b1;
              end
            end
          end
          W_FILL: begin
            if (w_accept) begin
              if (wr_sof) begin
                r_wptr     <= ADDR_WIDTH'(1);
                r_sync_err <= 1'b1;
              end else if (w_last) begin
                r_state <= W_WAIT;
              end else begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
              end
            end
          end
          W_WAIT: begin
            r_state <= W_WAIT;
          end
          default: begin
            r_state <= W_IDLE;
          end
        endcase
      end
    end
  end

  // Read side bookkeeping: which bank was sampled and whether the address was valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_sel <= r_rbank;
        r_rd_oob <= ~w_rd_in_range;
      end
    end
  end

  assign rd_data     = r_rd_oob ? {DATA_WIDTH{1'b0}} : (r_rd_sel ? w_rdata1 : w_rdata0);
  assign rd_valid    = r_rd_valid;
  assign sync_err    = r_sync_err;
  assign frame_avail = r_frame_avail;
  assign frame_id    = r_frame_id;

endmodule

// File: tb/tb_mnist_frame_pingpong.sv
// Scenario-driven bench for mnist_frame_pingpong; reads are scored against a queue of expected pixels.
module tb_mnist_frame_pingpong;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_sof = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       sync_err;
  logic       rd_en = 1'b0;
  logic [9:0] rd_addr = 10'd0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_avail;
  logic       frame_release = 1'b0;
  logic [7:0] frame_id;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_sync = 0;
  logic [7:0] sb_q[$];

  mnist_frame_pingpong #(
    .DATA_WIDTH(8), .IMG_ROWS(28), .IMG_COLS(28), .ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
    .wr_ready(wr_ready), .sync_err(sync_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_avail(frame_avail),
    .frame_release(frame_release), .frame_id(frame_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int pat, input int j);
    int v;
    case (pat)
      1:       v = ~j;
      3:       v = j * 3 + 7;
      5:       v = j ^ 32'h5A;
      6:       v = j + 64;
      default: v = j;
    endcase
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (sync_err === 1'b1) n_sync++;
  endtask

  task automatic stream(input int first, input int last, input int pat, input bit sof_first);
    for (int j = first; j <= last; j++) begin
      wr_valid = 1'b1;
      wr_sof   = sof_first && (j == first);
      wr_data  = pix(pat, j);
      tick();
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic issue_read(input int addr, input logic [7:0] exp_d);
    rd_en   = 1'b1;
    rd_addr = 10'(addr);
    sb_q.push_back(exp_d);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {frame_avail, rd_valid, sync_err, wr_ready, frame_id, rd_data};
    n_checks++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", got, {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_frame();
    int addrs[3];
    int s0;
    logic [7:0] e;
    addrs = '{0, 27, 783};
    s0 = n_sync;
    stream(0, 782, 0, 1'b1);
    n_checks++;
    if (frame_avail !== 1'b0) begin
      n_errors++;
      $display("FAIL avail_before_last: got %b expected 0", frame_avail);
    end
    stream(783, 783, 0, 1'b0);
    n_checks++;
    if (frame_avail !== 1'b1 || frame_id !== 8'd1 || wr_ready !== 1'b1 || n_sync != s0) begin
      n_errors++;
      $display("FAIL publish1: avail=%b id=%0d ready=%b syncs=%0d expected 1/1/1/%0d",
               frame_avail, frame_id, wr_ready, n_sync, s0);
    end
    for (int k = 0; k < 3; k++) begin
      issue_read(addrs[k], pix(0, addrs[k]));
      e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_errors++;
        $display("FAIL read_f1 addr %0d: valid=%b data=%h expected 1/%h", addrs[k], rd_valid, rd_data, e);
      end
    end
  endtask

  task automatic test_pending_frame();
    int addrs[3];
    int s0;
    logic [7:0] e;
    stream(0, 783, 1, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0 || frame_avail !== 1'b1 || frame_id !== 8'd1) begin
      n_errors++;
      $display("FAIL wait_state: ready=%b avail=%b id=%0d expected 0/1/1", wr_ready, frame_avail, frame_id);
    end
    s0 = n_sync;
    stream(0, 0, 0, 1'b1);
    n_checks++;
    if (n_sync != s0 || wr_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL wait_ignores_beat: syncs=%0d ready=%b expected %0d/0", n_sync, wr_ready, s0);
    end
    addrs = '{5, 783, 0};
    for (int k = 0; k < 2; k++) begin
      issue_read(addrs[k], pix(0, addrs[k]));
      e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_errors++;
        $display("FAIL read_still_f1 addr %0d: data=%h expected %h", addrs[k], rd_data, e);
      end
    end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    n_checks++;
    if (frame_id !== 8'd2 || frame_avail !== 1'b1 || wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL release_publish: id=%0d avail=%b ready=%b expected 2/1/1", frame_id, frame_avail, wr_ready);
    end
    addrs = '{0, 27, 783};
    for (int k = 0; k < 3; k++) begin
      issue_read(addrs[k], pix(1, addrs[k]));
      e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_errors++;
        $display("FAIL read_f2 addr %0d: data=%h expected %h", addrs[k], rd_data, e);
      end
    end
  endtask

  task automatic test_resync();
    int addrs[3];
    int s0;
    logic [7:0] e;
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    n_checks++;
    if (frame_avail !== 1'b0 || frame_id !== 8'd2) begin
      n_errors++;
      $display("FAIL release_drop: avail=%b id=%0d expected 0/2", frame_avail, frame_id);
    end
    s0 = n_sync;
    stream(0, 99, 0, 1'b1);
    stream(0, 0, 3, 1'b1);
    n_checks++;
    if (sync_err !== 1'b1 || n_sync != s0 + 1) begin
      n_errors++;
      $display("FAIL resync_pulse: sync_err=%b syncs=%0d expected 1/%0d", sync_err, n_sync, s0 + 1);
    end
    stream(1, 782, 3, 1'b0);
    n_checks++;
    if (frame_avail !== 1'b0 || n_sync != s0 + 1) begin
      n_errors++;
      $display("FAIL resync_no_early: avail=%b syncs=%0d expected 0/%0d", frame_avail, n_sync, s0 + 1);
    end
    stream(783, 783, 3, 1'b0);
    n_checks++;
    if (frame_avail !== 1'b1 || frame_id !== 8'd3) begin
      n_errors++;
      $display("FAIL resync_publish: avail=%b id=%0d expected 1/3", frame_avail, frame_id);
    end
    addrs = '{0, 100, 783};
    for (int k = 0; k < 3; k++) begin
      issue_read(addrs[k], pix(3, addrs[k]));
      e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_errors++;
        $display("FAIL read_f3 addr %0d: data=%h expected %h", addrs[k], rd_data, e);
      end
    end
  endtask

  task automatic test_idle_drop();
    int s0;
    s0 = n_sync;
    stream(0, 4, 0, 1'b0);
    n_checks++;
    if (n_sync != s0 + 5 || frame_avail !== 1'b1 || frame_id !== 8'd3 || wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_drop: syncs=%0d avail=%b id=%0d ready=%b expected %0d/1/3/1",
               n_sync, frame_avail, frame_id, wr_ready, s0 + 5);
    end
  endtask

  task automatic test_back_to_back();
    int addrs[3];
    logic [7:0] e;
    stream(0, 782, 5, 1'b1);
    n_checks++;
    if (frame_avail !== 1'b1 || frame_id !== 8'd3) begin
      n_errors++;
      $display("FAIL b2b_before: avail=%b id=%0d expected 1/3", frame_avail, frame_id);
    end
    wr_valid      = 1'b1;
    wr_data       = pix(5, 783);
    frame_release = 1'b1;
    rd_en         = 1'b1;
    rd_addr       = 10'd10;
    sb_q.push_back(pix(3, 10));
    tick();
    wr_valid      = 1'b0;
    frame_release = 1'b0;
    rd_en         = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== e) begin
      n_errors++;
      $display("FAIL read_pre_publish: data=%h expected %h", rd_data, e);
    end
    n_checks++;
    if (frame_avail !== 1'b1 || frame_id !== 8'd4) begin
      n_errors++;
      $display("FAIL b2b_publish: avail=%b id=%0d expected 1/4", frame_avail, frame_id);
    end
    tick();
    n_checks++;
    if (frame_avail !== 1'b1 || frame_id !== 8'd4) begin
      n_errors++;
      $display("FAIL b2b_single_inc: avail=%b id=%0d expected 1/4", frame_avail, frame_id);
    end
    addrs = '{0, 800, 783};
    for (int k = 0; k < 3; k++) begin
      issue_read(addrs[k], (addrs[k] >= 784) ? 8'h00 : pix(5, addrs[k]));
      e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_errors++;
        $display("FAIL read_f4 addr %0d: data=%h expected %h", addrs[k], rd_data, e);
      end
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== pix(5, 783)) begin
      n_errors++;
      $display("FAIL rd_hold: valid=%b data=%h expected 0/%h", rd_valid, rd_data, pix(5, 783));
    end
  endtask

  task automatic test_reset_midframe();
    logic [19:0] got;
    logic [7:0] e;
    stream(0, 398, 6, 1'b1);
    rd_en   = 1'b1;
    rd_addr = 10'd0;
    sb_q.push_back(pix(5, 0));
    stream(399, 399, 6, 1'b0);
    rd_en = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== e) begin
      n_errors++;
      $display("FAIL read_midframe: data=%h expected %h", rd_data, e);
    end
    rst_n = 1'b0;
    #1;
    got = {frame_avail, rd_valid, sync_err, wr_ready, frame_id, rd_data};
    n_checks++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_midframe: got %h expected %h", got, {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00});
    end
    tick();
    rst_n = 1'b1;
    stream(0, 783, 6, 1'b1);
    stream(0, 783, 1, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0 || frame_id !== 8'd1) begin
      n_errors++;
      $display("FAIL wait_before_reset: ready=%b id=%0d expected 0/1", wr_ready, frame_id);
    end
    rst_n = 1'b0;
    #1;
    got = {frame_avail, rd_valid, sync_err, wr_ready, frame_id, rd_data};
    n_checks++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_in_wait: got %h expected %h", got, {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00});
    end
    tick();
    rst_n = 1'b1;
    stream(0, 783, 6, 1'b1);
    n_checks++;
    if (frame_avail !== 1'b1 || frame_id !== 8'd1) begin
      n_errors++;
      $display("FAIL post_reset_publish: avail=%b id=%0d expected 1/1", frame_avail, frame_id);
    end
    for (int k = 0; k < 2; k++) begin
      issue_read(k * 783, pix(6, k * 783));
      e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_errors++;
        $display("FAIL read_post_reset addr %0d: data=%h expected %h", k * 783, rd_data, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pending_frame();
    test_resync();
    test_idle_drop();
    test_back_to_back();
    test_reset_midframe();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
